// File: rtl/obi_req_cut.sv
// obi_req_cut
// -----------------------------------------------------------------------------
// Registered cut on the OBI A channel (req/gnt) with an outstanding-transaction
// limiter. A 2-entry spill buffer decouples the upstream grant from the
// downstream grant. This keeps full throughput while removing the
// combinational gnt_i -> gnt_o path. The R channel and rready pass straight
// through.
//
// Parameters:
//   obi_a_chan_t  A channel payload type (addr, we, be, wdata, aid, a_optional)
//   obi_r_chan_t  R channel payload type (rdata, rid, err, r_optional)
//   MaxTrans      maximum number of in-flight transactions (>= 1)
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   sbr_a_chan_i   upstream A payload         mgr_a_chan_o  downstream A payload
//   req_i          upstream request           req_o         downstream request
//   gnt_o          upstream grant             gnt_i         downstream grant
//   sbr_r_chan_o   upstream R payload         mgr_r_chan_i  downstream R payload
//   rvalid_o       upstream response valid    rvalid_i      downstream response valid
//   rready_i       upstream response ready    rready_o      downstream response ready
// -----------------------------------------------------------------------------
module obi_req_cut #(
  parameter type         obi_a_chan_t = logic,
  parameter type         obi_r_chan_t = logic,
  parameter int unsigned MaxTrans     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  obi_a_chan_t sbr_a_chan_i,
  input  logic        req_i,
  output logic        gnt_o,
  output obi_r_chan_t sbr_r_chan_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  output obi_a_chan_t mgr_a_chan_o,
  output logic        req_o,
  input  logic        gnt_i,
  input  obi_r_chan_t mgr_r_chan_i,
  input  logic        rvalid_i,
  output logic        rready_o
);

  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        head_q, head_d;
  logic        wr_en;
  logic        wr_idx;
  obi_a_chan_t slot_q [2];
  logic [CntW-1:0] cnt_q;

  logic acc;
  logic pop;
  logic done;

  // The response channel is a pure wire-through. The cut only affects the
  // request direction.
  assign sbr_r_chan_o = mgr_r_chan_i;
  assign rvalid_o     = rvalid_i;
  assign rready_o     = rready_i;

  // Handshake events for the upstream accept, the downstream pop, and the
  // response completion.
  assign acc  = req_i & gnt_o;
  assign pop  = req_o & gnt_i;
  assign done = rvalid_o & rready_i;

  // The upstream grant only looks at registered state plus the response
  // completion. A completion in this cycle returns a credit immediately, so a
  // full counter can still accept. gnt_i never reaches this path.
  assign gnt_o = !rst_i && (state_q != FULL) &&
                 ((cnt_q != CntW'(MaxTrans)) || done);

  // Downstream side always presents the oldest buffered entry. The head moves
  // only on a pop, so the request stays stable while it waits for gnt_i.
  assign req_o        = (state_q != EMPTY);
  assign mgr_a_chan_o = slot_q[head_q];

  // Spill buffer next-state logic. With one entry held, the free slot is the
  // one opposite the head. On a simultaneous push and pop, the new entry lands
  // there and becomes the new head.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    wr_en   = 1'b0;
    wr_idx  = head_q;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d = ONE;
          wr_en   = 1'b1;
        end
      end
      ONE: begin
        wr_idx = ~head_q;
        if (acc && pop) begin
          wr_en  = 1'b1;
          head_d = ~head_q;
        end else if (acc) begin
          wr_en   = 1'b1;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
          head_d  = ~head_q;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          head_d  = ~head_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State and head pointer registers. A reset drops everything buffered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      head_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
    end
  end

  // Payload storage for the two spill slots.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else if (wr_en) begin
      slot_q[wr_idx] <= sbr_a_chan_i;
    end
  end

  // Outstanding counter. It runs from upstream accept to response completion,
  // so it includes entries still sitting in the buffer. A completion with
  // nothing outstanding is a protocol error; the counter holds at zero then.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (acc && !done) begin
      cnt_q <= cnt_q + CntW'(1);
    end else if (done && !acc && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

`ifndef SYNTHESIS
  // A stalled downstream request must keep its request and payload.
  a_stable_check : assert property (@(posedge clk_i) disable iff (rst_i)
    (req_o && !gnt_i) |=> (req_o && $stable(mgr_a_chan_o)));

  a_cnt_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    cnt_q <= CntW'(MaxTrans));

  a_no_spurious_done : assert property (@(posedge clk_i) disable iff (rst_i)
    !(done && (cnt_q == '0)));
`endif

endmodule

// File: tb/tb_obi_req_cut.sv
// tb_obi_req_cut
// -----------------------------------------------------------------------------
// Self-checking bench for obi_req_cut. Accepted upstream requests are queued
// as expected downstream payloads and compared when the DUT pops them. Each
// pop schedules a downstream response, which the bench returns after a
// configurable delay. The bench drives inputs on the falling edge and samples
// DUT outputs 1 time unit later.
// -----------------------------------------------------------------------------
module tb_obi_req_cut;

  localparam int MaxTrans = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
    logic        a_optional;
  } a_chan_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
    logic        r_optional;
  } r_chan_t;

  typedef struct {
    r_chan_t rsp;
    int      due;
  } pend_t;

  logic    clk_i = 1'b0;
  logic    rst_i;
  a_chan_t sbr_a_chan_i;
  logic    req_i;
  logic    gnt_o;
  r_chan_t sbr_r_chan_o;
  logic    rvalid_o;
  logic    rready_i;
  a_chan_t mgr_a_chan_o;
  logic    req_o;
  logic    gnt_i;
  r_chan_t mgr_r_chan_i;
  logic    rvalid_i;
  logic    rready_o;

  obi_req_cut #(
    .obi_a_chan_t(a_chan_t),
    .obi_r_chan_t(r_chan_t),
    .MaxTrans    (MaxTrans)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sbr_a_chan_i(sbr_a_chan_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .sbr_r_chan_o(sbr_r_chan_o),
    .rvalid_o    (rvalid_o),
    .rready_i    (rready_i),
    .mgr_a_chan_o(mgr_a_chan_o),
    .req_o       (req_o),
    .gnt_i       (gnt_i),
    .mgr_r_chan_i(mgr_r_chan_i),
    .rvalid_i    (rvalid_i),
    .rready_o    (rready_o)
  );

  always #5 clk_i = ~clk_i;

  int      total = 0;
  int      bad   = 0;
  int      cyc   = 0;
  a_chan_t a_exp [$];
  pend_t   rsp_q [$];
  int      acc_count  = 0;
  int      done_count = 0;
  int      up_seq     = 0;
  int      rsp_delay  = 1;
  bit      rsp_en     = 1'b1;
  int      grants;
  logic    obs_gnt, obs_done, obs_acc;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic a_chan_t mkReq(input int seq);
    a_chan_t a;
    a.addr       = 32'h1000 + 32'(seq) * 32'd4;
    a.we         = seq[0];
    a.be         = 4'hF;
    a.wdata      = 32'hC0DE_0000 | 32'(seq);
    a.aid        = 4'(seq);
    a.a_optional = 1'b0;
    return a;
  endfunction

  // One clock cycle. The bench drives the downstream response model, then
  // checks the outputs against the scoreboard-derived expectations. It
  // records the handshakes and advances to the next falling edge.
  task automatic applyStimulus();
    bit      done_now;
    int      outstanding;
    a_chan_t p;
    r_chan_t r;
    pend_t   pe;
    if (rsp_en && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      rvalid_i     = 1'b1;
      mgr_r_chan_i = rsp_q[0].rsp;
    end else begin
      rvalid_i     = 1'b0;
      mgr_r_chan_i = '0;
    end
    #1;
    done_now    = rvalid_i && rready_i;
    outstanding = acc_count - done_count;
    checkOutput("req_o", req_o, a_exp.size() != 0);
    checkOutput("gnt_o", gnt_o,
                (a_exp.size() < 2) && ((outstanding < MaxTrans) || done_now));
    checkOutput("rvalid_o", rvalid_o, rvalid_i);
    checkOutput("rready_o", rready_o, rready_i);
    if (rvalid_i) checkOutput("r_chan", sbr_r_chan_o, mgr_r_chan_i);
    obs_gnt  = gnt_o;
    obs_done = done_now;
    obs_acc  = req_i && gnt_o;
    if (req_o && gnt_i && a_exp.size() != 0) begin
      p = a_exp.pop_front();
      checkOutput("a_payload", mgr_a_chan_o, p);
      r.rdata      = p.wdata ^ 32'hA5A5_A5A5;
      r.rid        = p.aid;
      r.err        = 1'b0;
      r.r_optional = p.we;
      pe.rsp       = r;
      pe.due       = cyc + rsp_delay;
      rsp_q.push_back(pe);
    end
    if (obs_acc) begin
      a_exp.push_back(sbr_a_chan_i);
      acc_count++;
    end
    if (done_now) begin
      void'(rsp_q.pop_front());
      done_count++;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    if (obs_acc) begin
      up_seq++;
      sbr_a_chan_i = mkReq(up_seq);
    end
  endtask

  // Runs cycles until everything accepted has been popped and answered.
  // The loop has a fixed cycle budget.
  task automatic drainAll(input string tag);
    for (int i = 0; i < 40 && (a_exp.size() != 0 || rsp_q.size() != 0); i++)
      applyStimulus();
    checkOutput({tag, "_drained"}, a_exp.size() + rsp_q.size(), 0);
    checkOutput({tag, "_cnt_zero"}, dut.cnt_q, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    a_chan_t s1;
    req_i        = 1'b0;
    gnt_i        = 1'b0;
    rready_i     = 1'b1;
    rvalid_i     = 1'b0;
    mgr_r_chan_i = '0;
    sbr_a_chan_i = mkReq(0);
    rst_i        = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_req_o", req_o, 0);
    checkOutput("rst_gnt_o", gnt_o, 0);
    rst_i = 1'b0;
    #1;
    checkOutput("rst_cnt", dut.cnt_q, 0);

    // Single write with a response two cycles after the downstream grant.
    s1.addr = 32'h100; s1.we = 1'b1; s1.be = 4'hF; s1.wdata = 32'hDEAD_BEEF;
    s1.aid = 4'h1; s1.a_optional = 1'b0;
    sbr_a_chan_i = s1;
    req_i = 1'b1; gnt_i = 1'b1; rsp_delay = 2;
    applyStimulus();
    checkOutput("s1_acc", obs_acc, 1);
    req_i = 1'b0;
    checkOutput("s1_cnt_a", dut.cnt_q, 1);
    checkOutput("s1_req_o", req_o, 1);
    checkOutput("s1_a_chan", mgr_a_chan_o, s1);
    applyStimulus();
    checkOutput("s1_cnt_b", dut.cnt_q, 1);
    applyStimulus();
    checkOutput("s1_cnt_c", dut.cnt_q, 1);
    applyStimulus();
    checkOutput("s1_done", obs_done, 1);
    checkOutput("s1_cnt_d", dut.cnt_q, 0);

    // Back-to-back burst of 8 with one-cycle responses: no bubbles.
    rsp_delay = 1; req_i = 1'b1; grants = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      grants += int'(obs_acc);
    end
    checkOutput("s2_grants", grants, 8);
    req_i = 1'b0;
    drainAll("s2");

    // Downstream stalled: two accepts fill the buffer, then the grant drops.
    gnt_i = 1'b0; req_i = 1'b1; grants = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      grants += int'(obs_acc);
      checkOutput("s3_a_stable", mgr_a_chan_o, a_exp[0]);
    end
    checkOutput("s3_grants", grants, 2);
    checkOutput("s3_gnt_blocked", obs_gnt, 0);
    req_i = 1'b0; gnt_i = 1'b1;
    drainAll("s3");
    req_i = 1'b1;
    applyStimulus();
    checkOutput("s3_gnt_back", obs_gnt, 1);
    req_i = 1'b0;
    drainAll("s3b");

    // Outstanding cap: responses withheld, then released together with a
    // pending request.
    rsp_en = 1'b0; gnt_i = 1'b1; req_i = 1'b1; grants = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      grants += int'(obs_acc);
    end
    checkOutput("s4_grants", grants, MaxTrans);
    checkOutput("s4_gnt_capped", obs_gnt, 0);
    checkOutput("s4_cnt_full", dut.cnt_q, MaxTrans);
    rsp_en = 1'b1;
    applyStimulus();
    checkOutput("s4_done", obs_done, 1);
    checkOutput("s4_gnt_same_cycle", obs_gnt, 1);
    checkOutput("s4_cnt_hold", dut.cnt_q, MaxTrans);
    req_i = 1'b0;
    drainAll("s4");

    // rready held low: the response stays pending and the count holds.
    req_i = 1'b1;
    applyStimulus();
    req_i = 1'b0;
    applyStimulus();
    rready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("s5_no_done", obs_done, 0);
      checkOutput("s5_cnt_hold", dut.cnt_q, 1);
    end
    rready_i = 1'b1;
    applyStimulus();
    checkOutput("s5_done", obs_done, 1);
    checkOutput("s5_cnt_after", dut.cnt_q, 0);

    // Asynchronous reset with the buffer full and three outstanding.
    rsp_en = 1'b0; req_i = 1'b1; gnt_i = 1'b1;
    applyStimulus();
    applyStimulus();
    gnt_i = 1'b0;
    applyStimulus();
    #1;
    checkOutput("s6_cnt", dut.cnt_q, 3);
    checkOutput("s6_full_gnt", gnt_o, 0);
    checkOutput("s6_req_o", req_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("s6_rst_req_o", req_o, 0);
    checkOutput("s6_rst_gnt_o", gnt_o, 0);
    a_exp.delete();
    rsp_q.delete();
    acc_count = 0; done_count = 0;
    req_i = 1'b0; gnt_i = 1'b1; rsp_en = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checkOutput("s6_cnt_clear", dut.cnt_q, 0);
    checkOutput("s6_req_clear", req_o, 0);
    checkOutput("s6_gnt_ready", gnt_o, 1);
    req_i = 1'b1;
    applyStimulus();
    checkOutput("s6_new_acc", obs_acc, 1);
    req_i = 1'b0;
    drainAll("s6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
